// File: rtl/addsub_pkg.sv
// Shared types and constant helpers for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDS = 2'b10,
        OP_SUBS = 2'b11
    } op_e;

    // Widest operand the constant helpers below can describe.
    localparam int MAX_WIDTH = 256;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
        return r;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = MAX_WIDTH'(1) << (width - 1);
        return r;
    endfunction

    function automatic logic is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SUBS);
    endfunction

    function automatic logic is_sat(input op_e op);
        return (op == OP_ADDS) || (op == OP_SUBS);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One carry-chain segment: SEG-bit ripple add with carry-in, carry-out and the
// carry into the segment MSB (used to cross-check signed overflow).
module adder_segment
    import addsub_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);
    logic [SEG:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
        sum      = full[SEG-1:0];
        cout     = full[SEG];
        // sum = a ^ b ^ carry_in at every bit, so the MSB carry-in falls out directly
        c_msb_in = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Skewed-pipeline signed adder/subtractor: the carry chain is cut into STAGES
// segments, one register per segment, with valid/ready backpressure and saturation.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] i_1,
    input  logic signed [WIDTH-1:0] i_2,
    input  logic [1:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] o,
    output logic                    zero_flag,
    output logic                    overflow_flag,
    output logic                    carry_flag
);
    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(signed_max(WIDTH));
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(signed_min(WIDTH));

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    logic adv;

    // x_* is what stage k sees: the ports for k == 0, the previous register otherwise
    logic [WIDTH-1:0] x_a  [STAGES];
    logic [WIDTH-1:0] x_b  [STAGES];
    logic [WIDTH-1:0] x_s  [STAGES];
    logic             x_c  [STAGES];
    op_e              x_op [STAGES];
    logic             x_v  [STAGES];

    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_cout [STAGES];
    logic             seg_cmsb [STAGES];

    // Stage registers; entry LAST is superseded by the output register below
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_d   [STAGES];
    logic             c_q   [STAGES];
    op_e              op_d  [STAGES];
    op_e              op_q  [STAGES];
    logic             vld_d [STAGES];
    logic             vld_q [STAGES];

    logic [WIDTH-1:0]        fin_sum;
    logic [WIDTH-1:0]        fin_res;
    logic                    fin_ovf;
    logic                    out_valid_d, out_valid_q;
    logic signed [WIDTH-1:0] o_d, o_q;
    logic                    zero_d, zero_q;
    logic                    ovf_d, ovf_q;
    logic                    carry_d, carry_q;

    assign adv           = !out_valid_q || out_ready;
    assign in_ready      = adv;
    assign out_valid     = out_valid_q;
    assign o             = o_q;
    assign zero_flag     = zero_q;
    assign overflow_flag = ovf_q;
    assign carry_flag    = carry_q;

    // ---- stage inputs: subtract enters as A + ~B + 1 ----
    always_comb begin
        x_a[0]  = i_1;
        x_b[0]  = is_sub(op_e'(op)) ? ~i_2 : i_2;
        x_s[0]  = '0;
        x_c[0]  = is_sub(op_e'(op));
        x_op[0] = op_e'(op);
        x_v[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            x_a[k]  = a_q[k-1];
            x_b[k]  = b_q[k-1];
            x_s[k]  = s_q[k-1];
            x_c[k]  = c_q[k-1];
            x_op[k] = op_q[k-1];
            x_v[k]  = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(
            .SEG(SEG)
        ) u_seg (
            .a        (x_a[k][k*SEG +: SEG]),
            .b        (x_b[k][k*SEG +: SEG]),
            .cin      (x_c[k]),
            .sum      (seg_sum[k]),
            .cout     (seg_cout[k]),
            .c_msb_in (seg_cmsb[k])
        );
    end

    // ---- stage registers: every stage holds as one while the output is stalled ----
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            c_d[k]   = c_q[k];
            op_d[k]  = op_q[k];
            vld_d[k] = vld_q[k];
            if (adv) begin
                a_d[k]   = x_a[k];
                b_d[k]   = x_b[k];
                s_d[k]   = x_s[k];
                s_d[k][k*SEG +: SEG] = seg_sum[k];
                c_d[k]   = seg_cout[k];
                op_d[k]  = x_op[k];
                vld_d[k] = x_v[k];
            end
        end
    end

    // ---- final stage: overflow, saturation and flags, loaded only by valid beats ----
    always_comb begin
        fin_sum = x_s[LAST];
        fin_sum[LAST*SEG +: SEG] = seg_sum[LAST];
        fin_ovf = (x_a[LAST][MSB] == x_b[LAST][MSB]) && (fin_sum[MSB] != x_a[LAST][MSB]);
        fin_res = fin_sum;
        if (is_sat(x_op[LAST]) && fin_ovf) begin
            fin_res = x_a[LAST][MSB] ? SAT_MIN : SAT_MAX;
        end

        out_valid_d = out_valid_q;
        o_d         = o_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        if (adv) begin
            out_valid_d = x_v[LAST];
            if (x_v[LAST]) begin
                o_d     = fin_res;
                zero_d  = (fin_res == '0);
                ovf_d   = fin_ovf;
                carry_d = seg_cout[LAST];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            o_q         <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
            end
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            a_q[k]  <= a_d[k];
            b_q[k]  <= b_d[k];
            s_q[k]  <= s_d[k];
            c_q[k]  <= c_d[k];
            op_q[k] <= op_d[k];
        end
        // the sign-rule overflow must agree with carry-in xor carry-out of the MSB
        if (adv && x_v[LAST]) begin
            assert (fin_ovf == (seg_cout[LAST] ^ seg_cmsb[LAST]));
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three depths (4, 1, 32) share one stimulus stream and
// are scored against a plain-arithmetic reference model.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] i_1;
    logic [31:0] i_2;
    logic [1:0]  op;
    logic        out_ready;

    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic [31:0] o         [NI];
    logic        zf        [NI];
    logic        of        [NI];
    logic        cf        [NI];

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          nostall;

    logic [34:0] exp_mem [NI][64];
    int          acc_cyc [NI][64];
    int          wp [NI];
    int          rp [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_st4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .i_1(i_1), .i_2(i_2), .op(op), .out_valid(out_valid[0]), .out_ready(out_ready),
        .o(o[0]), .zero_flag(zf[0]), .overflow_flag(of[0]), .carry_flag(cf[0]));

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_st1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .i_1(i_1), .i_2(i_2), .op(op), .out_valid(out_valid[1]), .out_ready(out_ready),
        .o(o[1]), .zero_flag(zf[1]), .overflow_flag(of[1]), .carry_flag(cf[1]));

    pipelined_addsub #(.WIDTH(32), .STAGES(32)) u_st32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .i_1(i_1), .i_2(i_2), .op(op), .out_valid(out_valid[2]), .out_ready(out_ready),
        .o(o[2]), .zero_flag(zf[2]), .overflow_flag(of[2]), .carry_flag(cf[2]));

    function automatic int stages_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 32);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, packed as {zero, overflow, carry, result}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] opc);
        longint      sa, sb, r;
        logic [31:0] res;
        logic        ovf, cy;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = opc[0] ? (sa - sb) : (sa + sb);
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        cy  = opc[0] ? (a >= b) : ((longint'(a) + longint'(b)) > 64'sh0FFFFFFFF);
        if (opc[1] && ovf) res = (r > 0) ? 32'h7FFFFFFF : 32'h80000000;
        else               res = r[31:0];
        return {(res == 32'h0), ovf, cy, res};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'hFFFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard: every visible result is compared with the head of its instance queue
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("in_ready%0d", i), in_ready[i], !out_valid[i] || out_ready);
                if (out_valid[i]) begin
                    if (rp[i] == wp[i]) begin
                        chk($sformatf("spurious%0d", i), out_valid[i], 0);
                    end else begin
                        chk($sformatf("res%0d", i), {zf[i], of[i], cf[i], o[i]}, exp_mem[i][rp[i] % 64]);
                        if (out_ready) begin
                            if (nostall)
                                chk($sformatf("lat%0d", i), cyc - acc_cyc[i][rp[i] % 64], stages_of(i));
                            rp[i]++;
                        end
                    end
                end
                if (in_valid && in_ready[i]) begin
                    exp_mem[i][wp[i] % 64] = model(i_1, i_2, op);
                    acc_cyc[i][wp[i] % 64] = cyc;
                    wp[i]++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        i_1 = a;
        i_2 = b;
        op  = opc;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready[0];
            @(posedge clk);
            #1;
        end
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [34:0] exp);
        bit seen;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (out_valid[0] && out_ready) begin
                seen = 1;
                chk(tag, {zf[0], of[0], cf[0], o[0]}, exp);
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_seen"}, seen, 1);
    endtask

    task automatic drain();
        int busy;
        busy = 1;
        for (int t = 0; t < 300 && busy != 0; t++) begin
            busy = 0;
            for (int i = 0; i < NI; i++) if (wp[i] != rp[i]) busy++;
            if (busy != 0) begin
                @(posedge clk);
                #1;
            end
        end
        chk("drain", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  sent, stall_left;
        bit  seen, acc;

        rst = 1'b1; in_valid = 1'b0; i_1 = '0; i_2 = '0; op = OP_ADD;
        out_ready = 1'b1; nostall = 1'b1;
        for (int i = 0; i < NI; i++) begin wp[i] = 0; rp[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_state%0d", i), {out_valid[i], zf[i], of[i], cf[i], o[i]}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived results for the 4-stage instance
        send(32'd15, 32'd39, OP_SUB);
        expect_out("sub_15_39", {3'b000, 32'hFFFFFFE8});
        drain();

        send(32'd272, 32'd203, OP_ADD);
        send(32'd210, 32'd230, OP_ADD);
        send(32'd0, 32'd1000, OP_ADD);
        expect_out("b2b_0", {3'b000, 32'd475});
        expect_out("b2b_1", {3'b000, 32'd440});
        expect_out("b2b_2", {3'b000, 32'd1000});
        drain();

        send(32'h7FFFFFFF, 32'd1, OP_ADD);
        send(32'h7FFFFFFF, 32'd1, OP_ADDS);
        send(32'h80000000, 32'd1, OP_SUBS);
        expect_out("add_wrap", {3'b010, 32'h80000000});
        expect_out("adds_max", {3'b010, 32'h7FFFFFFF});
        expect_out("subs_min", {3'b011, 32'h80000000});
        drain();

        send(32'hFFFFFFFD, 32'hFFFFFFFD, OP_SUB);
        expect_out("sub_zero", {3'b101, 32'h0});
        drain();

        // Backpressure: stall 3 cycles as soon as the first result shows
        nostall = 1'b0;
        sent = 0; stall_left = 3; seen = 0;
        for (int t = 0; t < 100 && (sent < 6 || wp[0] != rp[0]); t++) begin
            if (out_valid[0]) seen = 1;
            if (seen && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < 6);
            i_1 = 32'(sent * 1000 + 7);
            i_2 = 32'(sent * 3 + 1);
            op  = 2'(sent % 4);
            @(negedge clk);
            acc = in_valid && in_ready[0];
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_sent", sent, 6);
        chk("bp_stalls", stall_left, 0);
        drain();

        // Reset with beats in flight
        send(32'd11, 32'd22, OP_ADD);
        send(32'd33, 32'd44, OP_SUB);
        send(32'd55, 32'd66, OP_ADDS);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_async%0d", i), {out_valid[i], zf[i], of[i], cf[i], o[i]}, 0);
            rp[i] = wp[i];
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        nostall = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) chk($sformatf("post_rst_idle%0d", i), out_valid[i], 0);
            @(posedge clk);
            #1;
        end
        send(32'd5, 32'd6, OP_ADD);
        expect_out("post_rst_beat", {3'b000, 32'd11});
        drain();

        // Randomised stream with random backpressure
        nostall = 1'b0;
        for (int t = 0; t < 800; t++) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                i_1 = rnd_operand();
                i_2 = rnd_operand();
                op  = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            acc = in_valid && in_ready[0];
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined signed adder/subtractor, the clocked successor of the combinational `adder`. It splits the carry chain into `STAGES` equal segments, one pipeline register per segment, and accepts one operation per cycle behind a valid/ready handshake with backpressure. It adds a saturating mode and a carry output, and reports zero, overflow and carry flags aligned with each result. It sits between the operand-select logic and the ALU result mux of the 32-bit ALU.

## Interface
- `WIDTH`, 32, operand/result width in bits; must be ≥ 2.
- `STAGES`, 4, pipeline depth and number of carry segments; must be ≥ 1; `WIDTH % STAGES == 0` (elaboration-time assertion).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `i_1`  in  WIDTH  signed operand A.
- `i_2`  in  WIDTH  signed operand B.
- `op`  in  2  00 add, 01 sub, 10 saturating add, 11 saturating sub.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result.
- `o`  out  WIDTH  signed result.
- `zero_flag`  out  1  `o == 0`, evaluated after saturation.
- `overflow_flag`  out  1  signed overflow of the unsaturated operation.
- `carry_flag`  out  1  carry-out of the MSB (for sub: 1 = no borrow).

## Operation
- Subtract is computed as `i_1 + ~i_2 + 1`. `op[0]` inverts B and forces the segment-0 carry-in to 1.
- Segment k adds bits `[k*SEG +: SEG]`, where `SEG = WIDTH/STAGES`.
  - Its carry-out is registered and feeds segment k+1 one cycle later.
  - Operand bits not yet consumed travel down the pipe alongside it (skewed pipeline).
  - Finished sum bits are delayed to align with the last segment.
- Overflow = `(A[MSB] == B'[MSB]) && (S[MSB] != A[MSB])`, where `B'` is the possibly inverted B. This is evaluated in the final stage.
- Saturation applies when `op[1]` is set and overflow is asserted:
  - If `A[MSB] == 0`, `o = 2^(WIDTH-1) - 1`.
  - Otherwise, `o = -2^(WIDTH-1)`.
  - `overflow_flag` still reads 1.
  - `carry_flag` is the raw carry.
- `op` and the saturation decision travel with the beat. Mixed ops in flight are legal.

## Timing
- Reset values: `out_valid = 0`, `o = 0`, all flags 0. All internal valid bits are cleared.
- `rst` asserted mid-operation discards every in-flight beat. Nothing is emitted after release until a new beat is accepted.
- Advance enable `adv = !out_valid || out_ready`. `in_ready = adv`, combinational, with no dependency on `in_valid`.
- When `adv == 0`, every stage register holds, including its valid bit.
- Latency: a beat accepted at edge N appears with `out_valid = 1` after edge N+`STAGES`, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while `out_ready = 1`. Bubbles propagate as invalid stages and are not collapsed.
- `o` and the flags are stable while `out_valid && !out_ready`.
- `STAGES == 1`: the full-width add is registered once, latency 1.
- `STAGES == WIDTH`: each segment is 1 bit. This must still meet the same rules.

## Structure
- Package `addsub_pkg`:
  - `op_e` enum (`OP_ADD`, `OP_SUB`, `OP_ADDS`, `OP_SUBS`).
  - Localparam helpers for `SEG`.
  - Signed max/min constant functions of `WIDTH`.
- Sub-module `adder_segment`, parametrised by `SEG`:
  - Inputs: `a`, `b`, `cin`.
  - Outputs: `sum`, `cout`, and `c_msb_in`, the carry into its MSB, needed for the overflow cross-check.
  - Purely combinational. `STAGES` instances are generated.
- Top level: skew/deskew register arrays, valid chain, final-stage flag/saturation logic.

## Test plan
1. `WIDTH=32`, `STAGES=4`, `op=SUB`, `i_1=15`, `i_2=39` -> after 4 cycles `o=-24`, `overflow=0`, `carry=0`, `zero=0`.
2. Back-to-back ADD beats (272,203), (210,230), (0,1000) on consecutive cycles with `out_ready=1` -> results 475, 440, 1000 on three consecutive cycles starting at cycle 4.
3. Overflow and saturation pair:
   - `op=ADD`, `i_1=32'h7FFFFFFF`, `i_2=1` -> `o=32'h80000000`, `overflow=1`.
   - Same operands with `op=ADDS` -> `o=32'h7FFFFFFF`, `overflow=1`.
   - `op=SUBS`, `i_1=32'h80000000`, `i_2=1` -> `o=32'h80000000`, `overflow=1`.
4. Zero/carry: `op=SUB`, `i_1=i_2=32'hFFFFFFFD` -> `o=0`, `zero=1`, `carry=1`, `overflow=0`.
5. Backpressure: stream 6 beats while holding `out_ready=0` for 3 cycles after the first result.
   - `in_ready` drops in the same cycle as the stall.
   - The head result is held stable.
   - No beat is lost or duplicated; order is preserved.
6. Assert `rst` for 1 cycle with 3 beats in flight -> all outputs 0 immediately, and no `out_valid` until a new beat arrives 4 cycles later.
7. Repeat scenarios 1–4 with `STAGES=1` and `STAGES=32`, checking the matching latency.
